// File: rtl/spi_ram_pkg.sv
// Shared opcodes and output-register FSM states
// for the SPI-slave burst RAM.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_t;

endpackage

// File: rtl/spi_ram_array.sv
// Simple dual-port storage: sync write, registered
// read output that only moves when re is high.
module spi_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The output register doubles as the held read word.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-slave RAM: opcode decoder, independent write/read
// pointers, held tx_valid output and sticky overflow flag.
module spi_ram_burst #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              tx_ready,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              rd_ovf
);

  import spi_ram_pkg::*;

  state_t state, state_n;

  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wa_cmd, wd_cmd, ra_cmd, rd_cmd;
  logic              rd_go, drop;

  assign op   = din[DATA_W+1:DATA_W];
  assign addr = din[ADDR_W-1:0];
  assign data = din[DATA_W-1:0];

  always_comb begin
    wa_cmd = 1'b0;
    wd_cmd = 1'b0;
    ra_cmd = 1'b0;
    rd_cmd = 1'b0;
    if (rx_valid) begin
      unique case (1'b1)
        (op == OP_WR_ADDR): wa_cmd = 1'b1;
        (op == OP_WR_DATA): wd_cmd = 1'b1;
        (op == OP_RD_ADDR): ra_cmd = 1'b1;
        (op == OP_RD_DATA): rd_cmd = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_EMPTY;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    rd_go   = 1'b0;
    drop    = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (rd_cmd) begin
          rd_go   = 1'b1;
          state_n = ST_FULL;
        end
      end
      ST_FULL: begin
        if (rd_cmd) begin
          if (tx_ready) rd_go = 1'b1;
          else          drop  = 1'b1;
        end else if (tx_ready) begin
          state_n = ST_EMPTY;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_ovf <= 1'b0;
    end else begin
      if (wa_cmd)
        wr_ptr <= addr;
      else if (wd_cmd && AUTO_INC)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (ra_cmd)
        rd_ptr <= addr;
      else if (rd_go && AUTO_INC)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      // A drop in the clearing cycle must not be lost.
      if (drop)         rd_ovf <= 1'b1;
      else if (ovf_clr) rd_ovf <= 1'b0;
    end
  end

  assign tx_valid = (state == ST_FULL);

  spi_ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .arst_n(arst_n),
    .we    (wd_cmd),
    .waddr (wr_ptr),
    .wdata (data),
    .re    (rd_go),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench for spi_ram_burst: directed table,
// corner sequences and a randomized reference-model run.
module tb_spi_ram_burst;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  din;
  logic        rx_a, rx_b, tx_ready, ovf_clr;
  logic [17:0] din_w;
  logic        rx_w;
  logic [7:0]  dout_a, dout_b;
  logic [15:0] dout_w;
  logic        v_a, v_b, v_w, o_a, o_b, o_w;

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1'b1)) dut_a (
    .clk(clk), .arst_n(arst_n), .din(din), .rx_valid(rx_a),
    .tx_ready(tx_ready), .ovf_clr(ovf_clr),
    .dout(dout_a), .tx_valid(v_a), .rd_ovf(o_a));

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1'b0)) dut_b (
    .clk(clk), .arst_n(arst_n), .din(din), .rx_valid(rx_b),
    .tx_ready(tx_ready), .ovf_clr(ovf_clr),
    .dout(dout_b), .tx_valid(v_b), .rd_ovf(o_b));

  spi_ram_burst #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(1'b1)) dut_w (
    .clk(clk), .arst_n(arst_n), .din(din_w), .rx_valid(rx_w),
    .tx_ready(tx_ready), .ovf_clr(ovf_clr),
    .dout(dout_w), .tx_valid(v_w), .rd_ovf(o_w));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rxv;
    logic [1:0] op;
    logic [7:0] pl;
    logic       rdy;
    logic       clr;
    logic [7:0] e_dout;
    logic       e_v;
    logic       e_o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rxv, logic [1:0] op,
                              logic [7:0] pl, logic rdy,
                              logic clr, logic [7:0] ed,
                              logic ev, logic eo);
    vec_t v;
    v.rxv = rxv; v.op = op; v.pl = pl; v.rdy = rdy;
    v.clr = clr; v.e_dout = ed; v.e_v = ev; v.e_o = eo;
    return v;
  endfunction

  // Reference model for dut_a, from the command rules.
  logic [7:0] m_mem [256];
  logic [7:0] m_wp, m_rp, m_dout;
  bit         m_full, m_ovf;

  task automatic apply(input bit rxv, input logic [1:0] op,
                       input logic [7:0] pl, input bit rdy,
                       input bit clr, input string tag);
    bit drop;
    drop = 1'b0;
    din = {op, pl};
    rx_a = rxv;
    tx_ready = rdy;
    ovf_clr = clr;
    if (rxv && op == 2'b11) begin
      if (!m_full || rdy) begin
        m_dout = m_mem[m_rp];
        m_full = 1'b1;
        m_rp = m_rp + 8'd1;
      end else begin
        drop = 1'b1;
      end
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    if (rxv && op == 2'b00) m_wp = pl;
    if (rxv && op == 2'b01) begin
      m_mem[m_wp] = pl;
      m_wp = m_wp + 8'd1;
    end
    if (rxv && op == 2'b10) m_rp = pl;
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    cyc();
    check({tag, " dout"}, 32'(dout_a), 32'(m_dout));
    check({tag, " tx_valid"}, 32'(v_a), 32'(m_full));
    check({tag, " rd_ovf"}, 32'(o_a), 32'(m_ovf));
  endtask

  initial begin
    din = '0; rx_a = 0; rx_b = 0; tx_ready = 0; ovf_clr = 0;
    din_w = '0; rx_w = 0;

    // burst, overflow, same-address write, wrap-around
    tbl.push_back(mk(1, 2'd0, 8'h10, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 2'd1, 8'hA1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 2'd1, 8'hB2, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 2'd1, 8'hC3, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 2'd2, 8'h10, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 2'd3, 8'h00, 1, 0, 8'hA1, 1, 0));
    tbl.push_back(mk(1, 2'd3, 8'h00, 1, 0, 8'hB2, 1, 0));
    tbl.push_back(mk(1, 2'd3, 8'h00, 1, 0, 8'hC3, 1, 0));
    tbl.push_back(mk(0, 2'd0, 8'h00, 1, 0, 8'hC3, 0, 0));
    tbl.push_back(mk(1, 2'd1, 8'hD4, 0, 0, 8'hC3, 0, 0));
    tbl.push_back(mk(1, 2'd1, 8'hE5, 0, 0, 8'hC3, 0, 0));
    tbl.push_back(mk(1, 2'd3, 8'h00, 0, 0, 8'hD4, 1, 0));
    tbl.push_back(mk(1, 2'd3, 8'h00, 0, 0, 8'hD4, 1, 1));
    tbl.push_back(mk(0, 2'd0, 8'h00, 0, 0, 8'hD4, 1, 1));
    tbl.push_back(mk(1, 2'd3, 8'h00, 1, 0, 8'hE5, 1, 1));
    tbl.push_back(mk(0, 2'd0, 8'h00, 1, 1, 8'hE5, 0, 0));
    tbl.push_back(mk(1, 2'd2, 8'h10, 0, 0, 8'hE5, 0, 0));
    tbl.push_back(mk(1, 2'd3, 8'h00, 0, 0, 8'hA1, 1, 0));
    tbl.push_back(mk(1, 2'd3, 8'h00, 0, 1, 8'hA1, 1, 1));
    tbl.push_back(mk(1, 2'd0, 8'h10, 0, 0, 8'hA1, 1, 1));
    tbl.push_back(mk(1, 2'd1, 8'h77, 0, 0, 8'hA1, 1, 1));
    tbl.push_back(mk(1, 2'd2, 8'h10, 0, 0, 8'hA1, 1, 1));
    tbl.push_back(mk(1, 2'd3, 8'h00, 1, 0, 8'h77, 1, 1));
    tbl.push_back(mk(0, 2'd0, 8'h00, 1, 1, 8'h77, 0, 0));
    tbl.push_back(mk(1, 2'd0, 8'hFF, 0, 0, 8'h77, 0, 0));
    tbl.push_back(mk(1, 2'd1, 8'h55, 0, 0, 8'h77, 0, 0));
    tbl.push_back(mk(1, 2'd1, 8'h66, 0, 0, 8'h77, 0, 0));
    tbl.push_back(mk(1, 2'd2, 8'hFF, 0, 0, 8'h77, 0, 0));
    tbl.push_back(mk(1, 2'd3, 8'h00, 1, 0, 8'h55, 1, 0));
    tbl.push_back(mk(1, 2'd3, 8'h00, 1, 0, 8'h66, 1, 0));
    tbl.push_back(mk(0, 2'd0, 8'h00, 1, 0, 8'h66, 0, 0));

    cyc();
    cyc();
    check("reset dout", 32'(dout_a), 32'h0);
    check("reset tx_valid", 32'(v_a), 32'h0);
    check("reset rd_ovf", 32'(o_a), 32'h0);
    arst_n = 1'b1;

    foreach (tbl[i]) begin
      din = {tbl[i].op, tbl[i].pl};
      rx_a = tbl[i].rxv;
      tx_ready = tbl[i].rdy;
      ovf_clr = tbl[i].clr;
      cyc();
      check($sformatf("tbl%0d dout", i), 32'(dout_a), 32'(tbl[i].e_dout));
      check($sformatf("tbl%0d tx_valid", i), 32'(v_a), 32'(tbl[i].e_v));
      check($sformatf("tbl%0d rd_ovf", i), 32'(o_a), 32'(tbl[i].e_o));
    end
    rx_a = 0; ovf_clr = 0;

    // pointers hold without auto-increment
    rx_b = 1;
    tx_ready = 1;
    din = {2'd0, 8'h20}; cyc();
    din = {2'd1, 8'h11}; cyc();
    din = {2'd1, 8'h22}; cyc();
    din = {2'd2, 8'h20}; cyc();
    din = {2'd3, 8'h00}; cyc();
    check("noinc rd1", 32'(dout_b), 32'h22);
    check("noinc v1", 32'(v_b), 32'h1);
    din = {2'd3, 8'h00}; cyc();
    check("noinc rd2", 32'(dout_b), 32'h22);
    rx_b = 0;

    // wide config, upper address payload bits ignored
    rx_w = 1;
    din_w = {2'd0, 16'hFFF3}; cyc();
    din_w = {2'd1, 16'hBEEF}; cyc();
    din_w = {2'd2, 16'hAB03}; cyc();
    din_w = {2'd3, 16'h0000}; cyc();
    check("wide dout", 32'(dout_w), 32'hBEEF);
    check("wide tx_valid", 32'(v_w), 32'h1);
    rx_w = 0;

    // async reset while holding a word with overflow set
    rx_a = 1;
    tx_ready = 0;
    din = {2'd2, 8'h00}; cyc();
    din = {2'd3, 8'h00}; cyc();
    din = {2'd3, 8'h00}; cyc();
    check("pre-rst tx_valid", 32'(v_a), 32'h1);
    check("pre-rst rd_ovf", 32'(o_a), 32'h1);
    rx_a = 0;
    arst_n = 1'b0;
    #1;
    check("async rst dout", 32'(dout_a), 32'h0);
    check("async rst tx_valid", 32'(v_a), 32'h0);
    check("async rst rd_ovf", 32'(o_a), 32'h0);
    #2;
    arst_n = 1'b1;
    cyc();
    rx_a = 1;
    tx_ready = 1;
    din = {2'd2, 8'h00}; cyc();
    din = {2'd3, 8'h00}; cyc();
    check("post-rst rd", 32'(dout_a), 32'h66);
    check("post-rst v", 32'(v_a), 32'h1);
    rx_a = 0;

    // randomized run against the model from a clean reset
    arst_n = 1'b0;
    cyc();
    arst_n = 1'b1;
    m_wp = 0; m_rp = 0; m_dout = 0; m_full = 0; m_ovf = 0;
    apply(1, 2'd0, 8'h00, 1, 0, "fill addr");
    for (int k = 0; k < 256; k++)
      apply(1, 2'd1, 8'($urandom), 1, 0, "fill");
    for (int k = 0; k < 800; k++) begin
      apply($urandom_range(0, 3) != 0,
            2'($urandom),
            8'($urandom),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0,
            $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
